sdf_bf_stage_32: RTL
====================

Name: sdf_bf_stage_32

Overview:
- Radix-2 single-path delay-feedback (SDF) butterfly stage for the 32-point section of the 512-point FFT pipeline.
- Consumes the twiddle pair and the stage state produced by the 32-entry twiddle ROM controller.
- Buffers the first half-frame, performs the butterfly, and applies the twiddle to the difference path.
- Emits a continuous complex sample stream to the next stage.

Parameters:
- DEPTH, 32, delay-line length (half of the stage FFT size); power of two.
- DW, 24, signed two's-complement sample and twiddle width.
- FRAC, 8, fractional bits of the twiddle (256 = 1.0).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  din_r/din_i carry a valid sample this cycle.
- din_r  in  DW  input sample, real part.
- din_i  in  DW  input sample, imaginary part.
- state  in  2  0 = load, 1 = butterfly, 2 = twiddle, 3 = reserved.
- w_r  in  DW  twiddle real part; valid in the same cycle as state.
- w_i  in  DW  twiddle imaginary part; valid in the same cycle as state.
- out_valid  out  1  dout_r/dout_i are valid.
- dout_r  out  DW  output sample, real part.
- dout_i  out  DW  output sample, imaginary part.

Behaviour:
- Storage: the delay line is a circular buffer of DEPTH complex entries with a log2(DEPTH)-bit pointer ptr.
  - Read and write use the same address ptr, read-before-write; D denotes the entry read at ptr.
  - ptr increments modulo DEPTH on every "advance" cycle and wraps 31 -> 0.
- Input zeroing: X = din when in_valid = 1, otherwise X = 0.
  - In states 1 and 2, zeroing applies to the operand only; the advance still occurs, so a trailing frame can be flushed.
- state 0 (load):
  - Advance only when in_valid = 1: write X at ptr.
  - Output register: out_valid <= 0, dout <= 0.
- state 1 (butterfly): advance every cycle.
  - Output register: dout <= D + X.
  - Delay line: write D - X at ptr.
  - out_valid <= 1.
- state 2 (twiddle): advance every cycle.
  - Output register: dout <= cmul(D, w).
  - Delay line: write X at ptr.
  - out_valid <= 1.
- state 3 (reserved): no advance, no write; out_valid <= 0; dout holds its value.
- Latency: exactly 1 cycle from the state/din cycle to the registered dout/out_valid.
- Arithmetic:
  - Add/subtract is DW-bit two's complement and wraps on overflow; no saturation and no growth bit.
  - cmul: pr = D_r*w_r - D_i*w_i and pi = D_r*w_i + D_i*w_r, computed at 2*DW+1 bits.
  - Each result is arithmetic-shifted right by FRAC, then the low DW bits are kept (wrap).
  - The twiddle input is sampled in the same cycle as D; no internal twiddle pipelining.
- Reset (rst = 1 at a clock edge, including mid-frame):
  - ptr = 0, all buffer entries = 0, out_valid = 0, dout_r = dout_i = 0.
  - All inputs are ignored that cycle.
  - rst has priority over every state.
- Simultaneous events: a state change takes effect in the cycle it is presented; no lookahead.
- Reset/sequencing contract: the driving controller guarantees 32 load advances before the first state 1, and continuous 32/32 alternation of states 1 and 2 thereafter.
  - The stage does not check this sequencing.

Optional Feature:
- Macro: SDF_CMUL_ROUND_EN.
- Defined: 2^(FRAC-1) (128) is added to pr and pi before the right shift (round-half-up).
- Undefined: plain arithmetic-shift truncation toward minus infinity.
- Only the twiddle path is affected; the butterfly sums are exact.

Decomposition:
- Shared package fft_pkg:
  - DW, FRAC.
  - State encodings ST_LOAD = 2'd0, ST_BF = 2'd1, ST_TW = 2'd2.
  - Complex sample typedef {re, im}.
- One sub-module, cmul_q8: combinational complex multiply with shift and optional rounding, reused by later stages.

Test Plan:
1. Reset: rst high 2 cycles, then low with state 0 -> out_valid = 0, dout = (0,0); ptr restarts so the sample in the first load cycle lands at entry 0.
2. Impulse: load x[0] = (256,0), x[1..31] = 0; 32 state-1 cycles of zeros, then 32 state-2 cycles with w = (256,0) at the first -> state-1 first output (256,0); state-2 first output (256,0); all other outputs (0,0).
3. Constant: all 64 inputs (100,0) -> the 32 state-1 outputs are (200,0); the 32 state-2 outputs are (0,0).
4. Twiddle rotation: load x[16] = (256,0), second half zero; w at state-2 cycle 16 = (0,-256) -> dout = (0,-256) on that cycle's output; others (0,0).
5. Rounding: load x[1] = (3,0), second half zero; state-2 cycle 1 with w = (255,-25) -> dout = (2,-1) without SDF_CMUL_ROUND_EN; (3,0) with it defined.
6. Overflow and mid-frame reset:
   - Wrap: x[0] = (8388607,0) and second-half sample 0 = (1,0) -> state-1 output (-8388608,0).
   - Reset: rst asserted at state-1 cycle 10 -> next cycle out_valid = 0, dout = 0.
   - After reset, a fresh 64-sample frame reproduces the results of scenario 2.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the 512-point SDF FFT pipeline: sample widths,
// stage-state encodings and the complex sample type.
package fft_pkg;

    localparam int DW   = 24;
    localparam int FRAC = 8;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_BF   = 2'd1,
        ST_TW   = 2'd2,
        ST_RSV  = 2'd3
    } st_e;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

endpackage

// File: rtl/cmul_q8.sv
// Combinational complex multiply by a fixed-point twiddle, scaled down by FRAC bits.
// Macro SDF_CMUL_ROUND_EN: round half-up before the shift instead of truncating.
module cmul_q8 #(
    parameter int DW   = 24,
    parameter int FRAC = 8
) (
    input  logic signed [DW-1:0] a_r,
    input  logic signed [DW-1:0] a_i,
    input  logic signed [DW-1:0] w_r,
    input  logic signed [DW-1:0] w_i,
    output logic signed [DW-1:0] p_r,
    output logic signed [DW-1:0] p_i
);

    localparam int PW = 2 * DW + 1;

    logic signed [PW-1:0] ar_x, ai_x, wr_x, wi_x;
    logic signed [PW-1:0] pr_full, pi_full;
    logic signed [PW-1:0] pr_adj, pi_adj;

    assign ar_x = PW'(a_r);
    assign ai_x = PW'(a_i);
    assign wr_x = PW'(w_r);
    assign wi_x = PW'(w_i);

    assign pr_full = ar_x * wr_x - ai_x * wi_x;
    assign pi_full = ar_x * wi_x + ai_x * wr_x;

`ifdef SDF_CMUL_ROUND_EN
    localparam logic signed [PW-1:0] HALF_LSB = PW'(1) <<< (FRAC - 1);
    assign pr_adj = pr_full + HALF_LSB;
    assign pi_adj = pi_full + HALF_LSB;
`else
    assign pr_adj = pr_full;
    assign pi_adj = pi_full;
`endif

    // Arithmetic shift keeps the sign; the cast keeps only the low DW bits (wrap).
    assign p_r = DW'(pr_adj >>> FRAC);
    assign p_i = DW'(pi_adj >>> FRAC);

endmodule

// File: rtl/sdf_bf_stage_32.sv
// Radix-2 single-path delay-feedback butterfly stage with a DEPTH-entry delay line.
// Macro SDF_CMUL_ROUND_EN (in cmul_q8) selects rounding on the twiddle path.
module sdf_bf_stage_32
    import fft_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int DW    = fft_pkg::DW,
    parameter int FRAC  = fft_pkg::FRAC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] din_r,
    input  logic signed [DW-1:0] din_i,
    input  logic [1:0]           state,
    input  logic signed [DW-1:0] w_r,
    input  logic signed [DW-1:0] w_i,
    output logic                 out_valid,
    output logic signed [DW-1:0] dout_r,
    output logic signed [DW-1:0] dout_i
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic signed [DW-1:0] mem_r_q [DEPTH];
    logic signed [DW-1:0] mem_i_q [DEPTH];
    logic                 out_valid_q, out_valid_d;
    logic signed [DW-1:0] dout_r_q, dout_r_d, dout_i_q, dout_i_d;

    logic                 mem_we;
    logic signed [DW-1:0] wr_r, wr_i;
    logic signed [DW-1:0] x_r, x_i, d_r, d_i;
    logic signed [DW-1:0] tw_r, tw_i;
    st_e                  st;

    assign st  = st_e'(state);
    assign x_r = in_valid ? din_r : '0;
    assign x_i = in_valid ? din_i : '0;
    assign d_r = mem_r_q[ptr_q];
    assign d_i = mem_i_q[ptr_q];

    cmul_q8 #(.DW(DW), .FRAC(FRAC)) u_cmul (
        .a_r (d_r),
        .a_i (d_i),
        .w_r (w_r),
        .w_i (w_i),
        .p_r (tw_r),
        .p_i (tw_i)
    );

    always_comb begin
        ptr_d       = ptr_q;
        mem_we      = 1'b0;
        wr_r        = x_r;
        wr_i        = x_i;
        out_valid_d = 1'b0;
        dout_r_d    = dout_r_q;
        dout_i_d    = dout_i_q;
        case (st)
            ST_LOAD: begin
                // Gaps in the input stream do not advance the fill position.
                if (in_valid) begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_q + PTR_W'(1);
                end
                dout_r_d = '0;
                dout_i_d = '0;
            end
            ST_BF: begin
                mem_we      = 1'b1;
                ptr_d       = ptr_q + PTR_W'(1);
                wr_r        = d_r - x_r;
                wr_i        = d_i - x_i;
                dout_r_d    = d_r + x_r;
                dout_i_d    = d_i + x_i;
                out_valid_d = 1'b1;
            end
            ST_TW: begin
                mem_we      = 1'b1;
                ptr_d       = ptr_q + PTR_W'(1);
                dout_r_d    = tw_r;
                dout_i_d    = tw_i;
                out_valid_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            dout_r_q    <= '0;
            dout_i_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r_q[i] <= '0;
                mem_i_q[i] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            dout_r_q    <= dout_r_d;
            dout_i_q    <= dout_i_d;
            if (mem_we) begin
                mem_r_q[ptr_q] <= wr_r;
                mem_i_q[ptr_q] <= wr_i;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign dout_r    = dout_r_q;
    assign dout_i    = dout_i_q;

endmodule
